// File: rtl/conv_filter_stream.sv
// Streaming NxN 2-D convolution with frame-aware gating, double-buffered signed kernel
// and saturating fixed-point output. Three-stage pipeline: window, products, sum/saturate.
module conv_filter_stream #(
  parameter int N            = 3,
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int DATA_W       = 8,
  parameter int COEF_W       = 12,
  parameter int FIXED        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sop,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     coef_we,
  input  logic [5:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eof,
  output logic [DATA_W-1:0]        out_data
);

  localparam int NN     = N * N;
  localparam int CENTER = (N / 2) * N + (N / 2);
  localparam int CW     = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int RW     = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int AW     = $clog2(NN);
  localparam int PW     = DATA_W + COEF_W + 1;
  localparam int SW     = PW + $clog2(NN);

  localparam logic [CW-1:0]            LAST_COL = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0]            LAST_ROW = RW'(FRAME_HEIGHT - 1);
  localparam logic [CW-1:0]            GATE_COL = CW'(N - 1);
  localparam logic [RW-1:0]            GATE_ROW = RW'(N - 1);
  localparam logic [6:0]               NN_LIM   = 7'(NN);
  localparam logic signed [COEF_W-1:0] ONE_COEF = COEF_W'(1 << FIXED);
  localparam logic signed [SW-1:0]     PIX_MAX  = SW'((1 << DATA_W) - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t                   state_r, state_nx_s;
  logic [CW-1:0]            col_r, col_nx_s, cur_col_s;
  logic [RW-1:0]            row_r, row_nx_s, cur_row_s;
  logic                     accept_s, last_s, gate_s, sop_s, eof_s;
  logic                     v0_r, sop0_r, eof0_r, v1_r, sop1_r, eof1_r;
  logic signed [COEF_W-1:0] shadow_r [NN];
  logic signed [COEF_W-1:0] active_r [NN];
  logic [DATA_W-1:0]        win_r [N][N];
  logic [DATA_W-1:0]        lb_r [N-1][LINE_WIDTH];
  logic signed [PW-1:0]     prod_r [NN];
  logic signed [SW-1:0]     sum_s, shift_s;
  logic [DATA_W-1:0]        sat_s;

  // Acceptance, pixel position and frame state; in_sop restarts at (0,0) from any state
  always_comb begin
    state_nx_s = state_r;
    col_nx_s   = col_r;
    row_nx_s   = row_r;
    cur_col_s  = col_r;
    cur_row_s  = row_r;
    if (in_sop) begin
      cur_col_s = '0;
      cur_row_s = '0;
    end else begin
      cur_col_s = col_r;
      cur_row_s = row_r;
    end
    case (state_r)
      ST_IDLE:   accept_s = in_valid & in_sop;
      ST_ACTIVE: accept_s = in_valid;
      default:   accept_s = 1'b0;
    endcase
    last_s = (cur_row_s == LAST_ROW) && (cur_col_s == LAST_COL);
    gate_s = accept_s && (cur_row_s >= GATE_ROW) && (cur_col_s >= GATE_COL);
    sop_s  = gate_s && (cur_row_s == GATE_ROW) && (cur_col_s == GATE_COL);
    eof_s  = gate_s && last_s;
    if (accept_s) begin
      if (last_s) begin
        state_nx_s = ST_IDLE;
        col_nx_s   = '0;
        row_nx_s   = '0;
      end else if (cur_col_s == LAST_COL) begin
        state_nx_s = ST_ACTIVE;
        col_nx_s   = '0;
        row_nx_s   = cur_row_s + RW'(1);
      end else begin
        state_nx_s = ST_ACTIVE;
        col_nx_s   = cur_col_s + CW'(1);
        row_nx_s   = cur_row_s;
      end
    end else begin
      state_nx_s = state_r;
    end
  end

  // Frame state and position registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      col_r   <= '0;
      row_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      col_r   <= col_nx_s;
      row_r   <= row_nx_s;
    end
  end

  // Kernel banks: commit reads the old shadow, so a same-cycle write lands only in shadow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NN; k++) begin
        shadow_r[k] <= (k == CENTER) ? ONE_COEF : '0;
        active_r[k] <= (k == CENTER) ? ONE_COEF : '0;
      end
    end else begin
      if (accept_s && in_sop) active_r <= shadow_r;
      if (coef_we && ({1'b0, coef_addr} < NN_LIM)) shadow_r[coef_addr[AW-1:0]] <= coef_data;
    end
  end

  // Line buffers and window; contents are don't-care until gating selects them
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N - 1; c++)
          win_r[r][c] <= win_r[r][c+1];
      win_r[0][N-1] <= in_data;
      for (int i = 1; i < N; i++) win_r[i][N-1] <= lb_r[i-1][cur_col_s];
      lb_r[0][cur_col_s] <= in_data;
      for (int i = 1; i < N - 1; i++) lb_r[i][cur_col_s] <= lb_r[i-1][cur_col_s];
    end
  end

  // Products; window row 0 is the newest line, kernel row 0 is the oldest
  always_ff @(posedge clk) begin
    for (int kr = 0; kr < N; kr++)
      for (int kc = 0; kc < N; kc++)
        prod_r[kr*N+kc] <= $signed({1'b0, win_r[N-1-kr][kc]}) * active_r[kr*N+kc];
  end

  // Full-width sum, floor shift and clamp to the pixel range
  always_comb begin
    sum_s = '0;
    for (int k = 0; k < NN; k++) sum_s = sum_s + SW'(prod_r[k]);
    shift_s = sum_s >>> FIXED;
    if (shift_s[SW-1]) begin
      sat_s = '0;
    end else if (shift_s > PIX_MAX) begin
      sat_s = '1;
    end else begin
      sat_s = shift_s[DATA_W-1:0];
    end
  end

  // Valid/marker pipeline and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v0_r      <= 1'b0;
      sop0_r    <= 1'b0;
      eof0_r    <= 1'b0;
      v1_r      <= 1'b0;
      sop1_r    <= 1'b0;
      eof1_r    <= 1'b0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eof   <= 1'b0;
      out_data  <= '0;
    end else begin
      v0_r      <= gate_s;
      sop0_r    <= sop_s;
      eof0_r    <= eof_s;
      v1_r      <= v0_r;
      sop1_r    <= sop0_r;
      eof1_r    <= eof0_r;
      out_valid <= v1_r;
      out_sop   <= sop1_r;
      out_eof   <= eof1_r;
      out_data  <= v1_r ? sat_s : '0;
    end
  end

endmodule

// File: tb/tb_conv_filter_stream.sv
// Scoreboard bench for conv_filter_stream (N=3, 8x6 frames): a reference model computes
// each expected output from the stored frame image and the model kernel.
module tb_conv_filter_stream;
  localparam int N  = 3;
  localparam int LW = 8;
  localparam int FH = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        coef_we = 1'b0;
  logic [5:0]  coef_addr = 6'd0;
  logic [11:0] coef_data = 12'd0;
  logic        out_valid, out_sop, out_eof;
  logic [7:0]  out_data;

  conv_filter_stream #(.N(N), .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .DATA_W(8), .COEF_W(12), .FIXED(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_sop(out_sop), .out_eof(out_eof), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct { int data; int sop; int eof; int cyc; } exp_t;
  typedef struct { int addr; int data; } cw_t;

  exp_t sb[$];
  cw_t  cw_q[$];
  int   log_q[$];
  int   checks = 0, failures = 0, cyc = 0, n_out = 0, eof_cnt = 0;
  int   m_shadow[9], m_active[9];
  int   img[FH][LW];
  int   m_row, m_col;
  bit   m_busy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 9; k++) begin
      m_shadow[k] = (k == 4) ? 256 : 0;
      m_active[k] = (k == 4) ? 256 : 0;
    end
    m_row = 0; m_col = 0; m_busy = 1'b0;
  endfunction

  function automatic void model_step(bit v, bit s, int d, bit we, int a, int cd);
    bit   acc;
    int   sum;
    exp_t e;
    acc = v && (m_busy || s);
    if (acc && s) begin
      m_active = m_shadow;
      m_row = 0; m_col = 0; m_busy = 1'b1;
    end
    if (we && a < 9) m_shadow[a] = cd;
    if (acc) begin
      img[m_row][m_col] = d;
      if (m_row >= N - 1 && m_col >= N - 1) begin
        sum = 0;
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            sum += img[m_row-2+kr][m_col-2+kc] * m_active[kr*3+kc];
        sum = sum >>> 8;
        if (sum < 0) sum = 0;
        if (sum > 255) sum = 255;
        e.data = sum;
        e.sop  = (m_row == 2 && m_col == 2) ? 1 : 0;
        e.eof  = (m_row == FH - 1 && m_col == LW - 1) ? 1 : 0;
        e.cyc  = cyc + 3;
        sb.push_back(e);
      end
      if (m_row == FH - 1 && m_col == LW - 1) begin
        m_busy = 1'b0; m_row = 0; m_col = 0;
      end else if (m_col == LW - 1) begin
        m_col = 0; m_row++;
      end else begin
        m_col++;
      end
    end
  endfunction

  task automatic drive(bit v, bit s, int d);
    cw_t w;
    bit  we;
    @(negedge clk);
    we = 1'b0;
    w  = '{addr: 0, data: 0};
    if (cw_q.size() > 0) begin
      w  = cw_q.pop_front();
      we = 1'b1;
    end
    in_valid = v; in_sop = s; in_data = d[7:0];
    coef_we = we; coef_addr = w.addr[5:0]; coef_data = w.data[11:0];
    model_step(v, s, d, we, w.addr, w.data);
  endtask

  task automatic send_frame(int kind, int val, bit stall, int npix);
    int p = 0;
    while (p < npix) begin
      if (!stall || $urandom_range(0, 1) == 1) begin
        drive(1'b1, p == 0, (kind == 0) ? (8 * (p / LW) + (p % LW)) : val);
        p++;
      end else begin
        drive(1'b0, 1'b0, $urandom_range(0, 255));
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || cw_q.size() != 0) && t < 40) begin
      drive(1'b0, 1'b0, 0);
      t++;
    end
    repeat (3) drive(1'b0, 1'b0, 0);
    check_eq("drain", sb.size(), 0);
  endtask

  task automatic load_kernel(int centre, int others);
    for (int k = 0; k < 9; k++) cw_q.push_back('{addr: k, data: (k == 4) ? centre : others});
    drain();
  endtask

  task automatic check_log(string tag, int cnt, int first, int last);
    check_eq({tag, "_count"}, log_q.size(), cnt);
    check_eq({tag, "_first"}, (log_q.size() > 0) ? log_q[0] : -1, first);
    check_eq({tag, "_last"}, (log_q.size() > 0) ? log_q[log_q.size()-1] : -1, last);
    log_q.delete();
  endtask

  // Output monitor: every output is popped against the scoreboard, including its cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (out_valid) begin
        n_out++;
        log_q.push_back(int'(out_data));
        if (out_eof) eof_cnt++;
        if (sb.size() == 0) begin
          check_eq("unexpected_out", int'(out_valid), 0);
        end else begin
          e = sb.pop_front();
          check_eq("data", int'(out_data), e.data);
          check_eq("sop", int'(out_sop), e.sop);
          check_eq("eof", int'(out_eof), e.eof);
          check_eq("latency", cyc, e.cyc);
        end
      end else begin
        check_eq("idle_markers", int'({out_sop, out_eof}), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_sop", int'(out_sop), 0);
    check_eq("rst_eof", int'(out_eof), 0);
    check_eq("rst_data", int'(out_data), 0);
    rst = 1'b1;

    send_frame(0, 0, 1'b0, LW * FH);
    drain();
    check_log("ramp", 24, 9, 38);

    // Box kernel written during an identity frame, first write coincides with the commit
    for (int k = 0; k < 9; k++) cw_q.push_back('{addr: k, data: 28});
    cw_q.push_back('{addr: 9, data: 777});
    send_frame(0, 0, 1'b0, LW * FH);
    drain();
    check_log("dbuf_ident", 24, 9, 38);
    send_frame(1, 100, 1'b0, LW * FH);
    drain();
    check_log("box", 24, 98, 98);

    load_kernel(1024, 0);
    send_frame(1, 200, 1'b0, LW * FH);
    drain();
    check_log("sat_hi", 24, 255, 255);
    load_kernel(-256, 0);
    send_frame(1, 200, 1'b0, LW * FH);
    drain();
    check_log("sat_lo", 24, 0, 0);

    load_kernel(256, 0);
    send_frame(0, 0, 1'b1, LW * FH);
    drain();
    check_log("stall", 24, 9, 38);

    eof_cnt = 0;
    send_frame(0, 0, 1'b0, 20);
    send_frame(0, 0, 1'b0, LW * FH);
    drain();
    check_eq("trunc_eofs", eof_cnt, 1);
    check_log("trunc", 26, 9, 38);

    // Reset while outputs are streaming, then pixels without in_sop must be dropped
    send_frame(0, 0, 1'b0, 29);
    @(posedge clk);
    #2;
    rst = 1'b0;
    in_valid = 1'b0; in_sop = 1'b0; coef_we = 1'b0;
    #1;
    check_eq("async_rst_valid", int'(out_valid), 0);
    check_eq("async_rst_data", int'(out_data), 0);
    sb.delete();
    model_reset();
    log_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n0 = n_out;
    repeat (10) drive(1'b1, 1'b0, $urandom_range(0, 255));
    repeat (6) drive(1'b0, 1'b0, 0);
    check_eq("idle_drop", n_out - n0, 0);
    send_frame(0, 0, 1'b0, LW * FH);
    drain();
    check_log("post_rst", 24, 9, 38);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_filter_stream.md
# conv_filter_stream

Streaming NxN 2-D convolution filter with valid/start-of-frame handshaking, run-time loadable signed kernel and saturating fixed-point output. It sits in the vision pipeline between pixel capture and downstream thresholding. It generalises the fixed-kernel, free-running 3x3 filter to:
- any odd N;
- input stalls;
- frame-aware output gating;
- double-buffered coefficient loading.

## Interface
- N, 3, window size; odd, 3..7
- LINE_WIDTH, 640, pixels per input line
- FRAME_HEIGHT, 480, lines per input frame
- DATA_W, 8, unsigned pixel width
- COEF_W, 12, signed coefficient width
- FIXED, 8, coefficient fractional bits
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  pixel present this cycle
- in_sop  in  1  qualifies in_valid; marks pixel (row 0, col 0) of a frame
- in_data  in  DATA_W  pixel value
- coef_we  in  1  coefficient write strobe
- coef_addr  in  6  kernel index, row*N+col
- coef_data  in  COEF_W  signed coefficient
- out_valid  out  1  filtered pixel present
- out_sop  out  1  first output pixel of frame
- out_eof  out  1  last output pixel of frame
- out_data  out  DATA_W  filtered pixel

## Operation
- **Pixel acceptance:** a pixel is accepted on any cycle with in_valid=1.
- **Position counters:** col (0..LINE_WIDTH-1) and row (0..FRAME_HEIGHT-1) advance only on accepted pixels. col wraps to 0 and increments row.
- **in_sop:** an accepted pixel with in_sop=1 forces the position to (0,0), regardless of the current position. This applies mid-frame too: the partial frame is abandoned.
- **Frame end and idle state:** after pixel (FRAME_HEIGHT-1, LINE_WIDTH-1) the block enters IDLE. It also starts in IDLE out of reset.
  - In IDLE, accepted pixels without in_sop are dropped: not stored, no output.
  - States: IDLE -> (accepted in_sop) ACTIVE -> (last pixel accepted) IDLE.
- **Line buffers:** N-1 circular line buffers, each LINE_WIDTH deep, addressed by col. They write and shift only on accepted pixels.
- **Window:** an NxN window register shifts one column per accepted pixel. Row 0 is fed from in_data; row i is fed from line buffer i-1.
- **Output gating ("valid" mode):** an output is produced only when the accepted pixel has row>=N-1 and col>=N-1. The output frame is therefore (LINE_WIDTH-N+1) x (FRAME_HEIGHT-N+1).
- **Arithmetic:**
  - Each pixel is zero-extended to signed DATA_W+1 bits and multiplied by its signed coefficient.
  - Products are summed at full width, DATA_W+COEF_W+1+ceil(log2(N*N)) bits; no intermediate truncation.
  - The sum is arithmetic-shifted right by FIXED (floor), then saturated to [0, 2^DATA_W-1].
- **Kernel banks:**
  - coef_we writes the shadow bank at coef_addr. Writes with coef_addr>=N*N are ignored.
  - The active bank copies the shadow bank on the cycle an in_sop pixel is accepted; that pixel already uses the new kernel.
  - A write and a commit in the same cycle: the commit takes the old shadow value; the write lands in shadow only.
- **Output markers:**
  - out_sop accompanies output (N-1, N-1).
  - out_eof accompanies output (FRAME_HEIGHT-1, LINE_WIDTH-1).
  - Both are low whenever out_valid=0.

## Timing
- **Reset** (asynchronous assert; deassert is synchronised by the system):
  - out_valid, out_sop, out_eof, out_data = 0.
  - State = IDLE; counters = 0.
  - Both kernel banks = identity (centre = 1<<FIXED, all others 0).
  - Line buffer and window contents are not reset; output gating makes them don't-care.
- **Latency:**
  - Pipeline: edge k loads the window; edge k+1 registers the products; edge k+2 registers the sum/shift/saturate result.
  - For a pixel accepted at edge k, out_valid is high for exactly one cycle, after edge k+2.
  - Latency is independent of stalls; the pipeline advances every cycle.
- **Throughput:** one pixel per cycle; no back-pressure.
- **Reset mid-frame:** in-flight outputs are discarded. The first output after reset requires a new in_sop frame.
- **Truncated frame:** an in_sop arriving mid-frame never produces out_eof for the abandoned frame.

## Test plan
- **Identity ramp.** N=3, LINE_WIDTH=8, FRAME_HEIGHT=6; after reset, one frame with pixel = 8*row+col and in_valid held high.
  - Expect 24 outputs, each equal to the centre pixel of its window.
  - First output = 9 with out_sop; last output = 38 with out_eof.
- **Box blur.** All coefficients 28; constant-100 frame -> every output = (9*100*28)>>8 = 98.
- **Saturation.**
  - Centre coefficient 1024, others 0, pixel 200 -> 255.
  - Centre coefficient -256 -> 0.
- **Stalls.** The identity ramp with in_valid pseudo-randomly low for 50% of cycles.
  - Expect the same 24 values in order.
  - Each output appears exactly 2 cycles after acceptance of its bottom-right pixel.
- **Kernel double-buffering.**
  - Write the box kernel during frame 1 -> frame 1 outputs remain identity; frame 2 outputs equal 98 for constant 100.
  - A write with coef_addr=9 leaves all coefficients unchanged.
- **Reset and IDLE dropping.**
  - Assert rst mid-frame -> out_valid=0 and out_data=0 immediately, without waiting for a clock edge.
  - Pixels without in_sop are then dropped.
  - The next in_sop frame reproduces the identity-ramp results.
